// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types for the unified-memory port arbiter.
//   owner_t records which requester owns the SRAM response that
//   arrives in the cycle after a grant.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  // The arbiter's streak limit must be at least 1; otherwise LS could never win
  // while IF is waiting.
  localparam int MIN_LS_STREAK = 1;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous SRAM between the fetch path (IF,
//   read-only) and the load/store path (LS, read/write). At most one access is
//   granted per cycle. The 1-cycle read response is routed back to the
//   requester that was granted.
//
// Ports
//   clk, rst_n                 core clock (rising edge); async active-low reset
//   if_req/if_addr/if_flush    fetch request, word address, redirect-cancel
//   if_gnt/if_rvalid/if_rdata  fetch grant (comb), response valid, instruction
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata
//                              load/store request and qualifiers
//   ls_gnt/ls_rvalid/ls_rdata  LS grant (comb), completion, load data
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata
//                              SRAM command, driven by the winner
//   mem_rdata                  SRAM read data, valid the cycle after mem_en
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int                STREAK_W   = $clog2(MAX_LS_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  owner_t              owner_q;
  owner_t              owner_d;
  logic                ls_we_q;
  logic                ls_we_d;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  logic if_ok;
  logic ls_ok;
  logic if_starved;

  // Grant selection. LS normally wins a conflict because it belongs to the
  // older instruction. Once LS has won MAX_LS_STREAK times in a row while IF
  // waited, IF is let through so fetch cannot starve. Grants are gated by
  // rst_n so that nothing is granted while reset is asserted.
  always_comb begin
    if_ok      = rst_n & if_req & ~if_flush;
    ls_ok      = rst_n & ls_req;
    if_starved = if_ok & (streak_q == STREAK_MAX);
    ls_gnt     = ls_ok & ~if_starved;
    if_gnt     = if_ok & ~ls_gnt;
  end

  // Next owner and streak. The streak counts consecutive LS wins against a
  // waiting IF. It restarts whenever IF is served or stops asking, and it
  // saturates at the limit.
  always_comb begin
    owner_d  = OWN_NONE;
    ls_we_d  = 1'b0;
    streak_d = streak_q;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (ls_gnt) begin
      owner_d = OWN_LS;
      ls_we_d = ls_we;
    end
    if (if_gnt || !if_req) begin
      streak_d = '0;
    end else if (ls_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_ONE;
    end
  end

  // Owner, the registered store flag and the streak. An asynchronous reset
  // discards any response still owed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      ls_we_q  <= 1'b0;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      ls_we_q  <= ls_we_d;
      streak_q <= streak_d;
    end
  end

  // SRAM command from the winner, plus response routing. A fetch response is
  // suppressed when a redirect arrives in its response cycle. Store
  // completions return zero data.
  always_comb begin
    mem_en    = if_gnt | ls_gnt;
    mem_we    = ls_gnt & ls_we;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_be   = '1;
      mem_addr = if_addr;
    end else if (ls_gnt) begin
      mem_be    = ls_be;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end

    if_rvalid = (owner_q == OWN_IF) & ~if_flush;
    if_rdata  = (owner_q == OWN_IF) ? mem_rdata : '0;
    ls_rvalid = (owner_q == OWN_LS);
    ls_rdata  = ((owner_q == OWN_LS) && !ls_we_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. The stimulus process drives one
//   vector per cycle and pushes that cycle's expected outputs into a
//   scoreboard queue. A separate monitor pops one entry on each falling edge
//   and compares it against the DUT. A small byte-enabled SRAM model supplies
//   mem_rdata with hand-known contents.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        if_gnt;
    logic        ls_gnt;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_dc;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cycles = 0;
  logic        done = 1'b0;
  logic        pend_if = 1'b0;
  logic        pend_ls = 1'b0;
  logic [31:0] pend_if_word = '0;
  logic [31:0] pend_ls_word = '0;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_be     (ls_be),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: word i holds 0xC0DE0000|i, except word 0x40 (byte 0x100),
  // which holds a NOP (0x13). Idle cycles return garbage so stale data shows.
  logic [31:0] sram [0:255];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) sram[i] <= 32'hC0DE_0000 | 32'(i);
      sram[64]  <= 32'h0000_0013;
      mem_rdata <= '0;
    end else if (mem_en) begin
      mem_rdata <= sram[mem_addr[9:2]];
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end else begin
      mem_rdata <= 32'hDEAD_BEEF;
    end
  end

  // Drives one cycle of inputs, queues that cycle's expected outputs and
  // records which responses are owed next cycle. It is entered just after a
  // rising edge and returns just after the next one.
  task automatic applyStimulus(
    input logic        a_if_req,
    input logic [31:0] a_if_addr,
    input logic        a_if_flush,
    input logic        a_ls_req,
    input logic        a_ls_we,
    input logic [3:0]  a_ls_be,
    input logic [31:0] a_ls_addr,
    input logic [31:0] a_ls_wdata,
    input logic        x_if_gnt,
    input logic        x_ls_gnt,
    input logic [31:0] x_if_word,
    input logic [31:0] x_ls_word
  );
    exp_t e;
    if_req   = a_if_req;
    if_addr  = a_if_addr;
    if_flush = a_if_flush;
    ls_req   = a_ls_req;
    ls_we    = a_ls_we;
    ls_be    = a_ls_be;
    ls_addr  = a_ls_addr;
    ls_wdata = a_ls_wdata;
    e.if_gnt    = x_if_gnt;
    e.ls_gnt    = x_ls_gnt;
    e.mem_we    = x_ls_gnt & a_ls_we;
    e.mem_be    = x_if_gnt ? 4'hF : (x_ls_gnt ? a_ls_be : 4'h0);
    e.mem_addr  = x_if_gnt ? a_if_addr : (x_ls_gnt ? a_ls_addr : 32'h0);
    e.if_rvalid = pend_if & ~a_if_flush;
    e.if_rdata  = e.if_rvalid ? pend_if_word : 32'h0;
    e.if_dc     = pend_if & a_if_flush;
    e.ls_rvalid = pend_ls;
    e.ls_rdata  = pend_ls ? pend_ls_word : 32'h0;
    exp_q.push_back(e);
    pend_if      = x_if_gnt;
    pend_if_word = x_if_word;
    pend_ls      = x_ls_gnt;
    pend_ls_word = x_ls_word;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                  1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cycles);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, compared on the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cycles++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("grant", 64'({if_gnt, ls_gnt, mem_en}),
                    64'({e.if_gnt, e.ls_gnt, e.if_gnt | e.ls_gnt}));
        checkOutput("mem_cmd", 64'({mem_we, mem_be, mem_addr}),
                    64'({e.mem_we, e.mem_be, e.mem_addr}));
        if (e.if_dc) checkOutput("if_rvalid", 64'(if_rvalid), 64'(e.if_rvalid));
        else checkOutput("if_resp", 64'({if_rvalid, if_rdata}),
                         64'({e.if_rvalid, e.if_rdata}));
        checkOutput("ls_resp", 64'({ls_rvalid, ls_rdata}),
                    64'({e.ls_rvalid, e.ls_rdata}));
      end
      if (done && exp_q.size() == 0) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      if (cycles > 3000) begin
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: cycles=%0d limit=3000", cycles);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin : stimulus
    logic want_if;
    rst_n = 1'b1;
    if_req = 0; if_addr = 0; if_flush = 0;
    ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] reset phase");
    // Requests during reset are not granted.
    applyStimulus(1, 32'h100, 0, 1, 1, 4'hF, 32'h2000, 32'h1, 0, 0, 0, 0);
    applyStimulus(1, 32'h100, 0, 1, 0, 4'hF, 32'h2000, 32'h0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle();

    $display("[TB] IF only");
    applyStimulus(1, 32'h100, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h13, 0);
    idle();

    $display("[TB] conflict, LS load wins then IF");
    applyStimulus(1, 32'h104, 0, 1, 0, 4'hF, 32'h2000, 32'h0, 0, 1, 0, 32'hC0DE_0000);
    applyStimulus(1, 32'h104, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'hC0DE_0041, 0);
    idle();

    $display("[TB] partial store then load back");
    applyStimulus(0, 32'h0, 0, 1, 1, 4'b0011, 32'h2004, 32'h0000_BEEF, 0, 1, 0, 32'h0);
    applyStimulus(0, 32'h0, 0, 1, 0, 4'hF, 32'h2004, 32'h0, 0, 1, 0, 32'hC0DE_BEEF);
    idle();

    $display("[TB] LS streak limit");
    for (int k = 0; k < 10; k++) begin
      want_if = (k == 4) || (k == 9);
      applyStimulus(1, 32'h100, 0, 1, 0, 4'hF, 32'h2008, 32'h0,
                    want_if, ~want_if, 32'h13, 32'hC0DE_0002);
    end
    idle();

    $display("[TB] flush drops IF response");
    applyStimulus(1, 32'h104, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'hC0DE_0041, 0);
    applyStimulus(1, 32'h104, 1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    applyStimulus(1, 32'h104, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'hC0DE_0041, 0);
    idle();

    $display("[TB] flush does not drop LS");
    applyStimulus(1, 32'h104, 1, 1, 0, 4'hF, 32'h2000, 32'h0, 0, 1, 0, 32'hC0DE_0000);
    applyStimulus(1, 32'h104, 1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    applyStimulus(1, 32'h104, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'hC0DE_0041, 0);
    idle();

    $display("[TB] reset mid-operation");
    applyStimulus(1, 32'h100, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h13, 0);
    rst_n   = 1'b0;
    pend_if = 1'b0;
    pend_ls = 1'b0;
    applyStimulus(1, 32'h100, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    applyStimulus(1, 32'h100, 0, 1, 0, 4'hF, 32'h2000, 32'h0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle();
    idle();
    applyStimulus(1, 32'h100, 0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h13, 0);
    idle();

    done = 1'b1;
  end

endmodule
